// File: rtl/fsm_bit_stream_driver.sv
// Buffers parallel words in a DEPTH-entry FIFO and serializes them onto bit_out; first bit 2 edges after push to idle.
// in_ready drops only on a full FIFO (pops never relieve it same-cycle); step_en=0 freezes the shifter.
module fsm_bit_stream_driver #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   step_en,
  output logic                   bit_out,
  output logic                   bit_valid,
  output logic                   word_done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(WIDTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [BW-1:0]    bcnt, bcnt_nxt;
  logic             push, pop, done_nxt, bit_nxt;

  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  assign in_ready = (fifo_count < FULL);
  assign push     = in_valid && in_ready;
  assign busy     = (state == SHIFT) || (fifo_count != '0);

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    bcnt_nxt  = bcnt;
    pop       = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          pop       = 1'b1;
          shreg_nxt = mem[rd_ptr];
          bcnt_nxt  = LAST;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (step_en) begin
          if (bcnt != '0) begin
            shreg_nxt = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
            bcnt_nxt  = bcnt - 1'b1;
          end else begin
            done_nxt = 1'b1;
            // Chain straight into the next queued word so the stream has no gap bit.
            if (fifo_count != '0) begin
              pop       = 1'b1;
              shreg_nxt = mem[rd_ptr];
              bcnt_nxt  = LAST;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    bit_nxt = (state_nxt == SHIFT) ? head(shreg_nxt) : IDLE_BIT;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      shreg      <= '0;
      bcnt       <= '0;
      bit_out    <= IDLE_BIT;
      bit_valid  <= 1'b0;
      word_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      bcnt      <= bcnt_nxt;
      bit_out   <= bit_nxt;
      bit_valid <= (state_nxt == SHIFT);
      word_done <= done_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_bit_stream_driver.sv
// Directed bench: MSB-first/IDLE_BIT=0 instance (a_*) and LSB-first/IDLE_BIT=1 instance (b_*).
module tb_fsm_bit_stream_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] a_data = 8'h00, b_data = 8'h00;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic       a_step = 1'b0, b_step = 1'b0;
  logic       a_ready, a_bit, a_bv, a_done, a_busy;
  logic       b_ready, b_bit, b_bv, b_done, b_busy;
  logic [2:0] a_cnt, b_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fsm_bit_stream_driver #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_a (
    .clk(clk), .reset(reset), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .step_en(a_step), .bit_out(a_bit), .bit_valid(a_bv), .word_done(a_done),
    .busy(a_busy), .fifo_count(a_cnt)
  );

  fsm_bit_stream_driver #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_b (
    .clk(clk), .reset(reset), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .step_en(b_step), .bit_out(b_bit), .bit_valid(b_bv), .word_done(b_done),
    .busy(b_busy), .fifo_count(b_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input int idx, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d]: observed=%b expected=%b", tag, idx, obs, exp);
    end
  endtask

  task automatic chk_c(input string tag, input int idx, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d]: observed=%0d expected=%0d", tag, idx, obs, exp);
    end
  endtask

  initial begin
    logic [7:0]  w;
    logic [15:0] s16;
    logic [39:0] s40;
    logic [9:0]  pat;
    int          k;

    // Reset state of both instances.
    repeat (2) tick();
    chk_b("rst_a_bit", 0, a_bit, 1'b0);
    chk_b("rst_a_bv", 0, a_bv, 1'b0);
    chk_b("rst_a_done", 0, a_done, 1'b0);
    chk_b("rst_a_ready", 0, a_ready, 1'b1);
    chk_b("rst_a_busy", 0, a_busy, 1'b0);
    chk_c("rst_a_cnt", 0, a_cnt, 3'd0);
    chk_b("rst_b_bit", 0, b_bit, 1'b1);
    chk_b("rst_b_bv", 0, b_bv, 1'b0);
    reset = 1'b0;
    tick();

    // Single word 8'hB4, step_en held high.
    w = 8'hB4;
    a_data = w; a_valid = 1'b1; a_step = 1'b1;
    tick();
    a_valid = 1'b0;
    chk_b("b4_bv_e0", 0, a_bv, 1'b0);
    chk_c("b4_cnt_e0", 0, a_cnt, 3'd1);
    chk_b("b4_busy_e0", 0, a_busy, 1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk_b("b4_bv", i, a_bv, 1'b1);
      chk_b("b4_bit", i, a_bit, w[7-i]);
      chk_b("b4_done", i, a_done, 1'b0);
      tick();
    end
    chk_b("b4_done_end", 0, a_done, 1'b1);
    chk_b("b4_bv_end", 0, a_bv, 1'b0);
    chk_b("b4_bit_end", 0, a_bit, 1'b0);
    chk_b("b4_busy_end", 0, a_busy, 1'b0);
    tick();
    chk_b("b4_done_clr", 0, a_done, 1'b0);

    // Back-to-back 8'hA5, 8'h3C: 16 contiguous bits.
    s16 = 16'hA53C;
    a_data = 8'hA5; a_valid = 1'b1;
    tick();
    a_data = 8'h3C;
    tick();
    a_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk_b("b2b_bv", i, a_bv, 1'b1);
      chk_b("b2b_bit", i, a_bit, s16[15-i]);
      chk_b("b2b_done", i, a_done, (i == 8));
      tick();
    end
    chk_b("b2b_done_end", 0, a_done, 1'b1);
    chk_b("b2b_bv_end", 0, a_bv, 1'b0);
    tick();

    // Fill with step_en low: 5 pushes land (one in shifter, four in FIFO).
    s40 = 40'h11_22_33_44_55;
    a_step = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_data = s40[39-8*i -: 8]; a_valid = 1'b1;
      tick();
    end
    chk_c("full_cnt", 0, a_cnt, 3'd4);
    chk_b("full_ready", 0, a_ready, 1'b0);
    chk_b("full_bv", 0, a_bv, 1'b1);
    chk_b("full_bit", 0, a_bit, 1'b0);
    a_data = 8'h66;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_c("full_hold_cnt", i, a_cnt, 3'd4);
      chk_b("full_hold_ready", i, a_ready, 1'b0);
    end
    a_valid = 1'b0; a_step = 1'b1;
    for (int i = 0; i < 40; i++) begin
      chk_b("drain_bv", i, a_bv, 1'b1);
      chk_b("drain_bit", i, a_bit, s40[39-i]);
      tick();
    end
    chk_b("drain_bv_end", 0, a_bv, 1'b0);
    chk_c("drain_cnt_end", 0, a_cnt, 3'd0);
    chk_b("drain_busy_end", 0, a_busy, 1'b0);
    chk_b("drain_done_end", 0, a_done, 1'b1);
    tick();

    // 8'hF0 with step_en stalls mid-word.
    w = 8'hF0;
    pat = 10'b11111_00111;
    a_data = w; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    tick();
    k = 0;
    for (int c = 0; c < 10; c++) begin
      a_step = pat[c];
      chk_b("stall_bv", c, a_bv, 1'b1);
      chk_b("stall_bit", c, a_bit, w[7-k]);
      chk_b("stall_done", c, a_done, 1'b0);
      tick();
      if (pat[c]) k++;
    end
    chk_b("stall_bv_end", 0, a_bv, 1'b0);
    chk_b("stall_done_end", 0, a_done, 1'b1);
    tick();

    // Reset after the 3rd bit of 8'h81 with two words queued.
    w = 8'h81;
    a_step = 1'b0;
    a_data = 8'h81; a_valid = 1'b1; tick();
    a_data = 8'h7E; tick();
    a_data = 8'h99; tick();
    a_valid = 1'b0;
    chk_c("rmid_cnt", 0, a_cnt, 3'd2);
    a_step = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_b("rmid_bit", i, a_bit, w[7-i]);
      if (i < 2) tick();
    end
    reset = 1'b1;
    #1;
    chk_b("rmid_bv", 0, a_bv, 1'b0);
    chk_b("rmid_bit0", 0, a_bit, 1'b0);
    chk_c("rmid_cnt0", 0, a_cnt, 3'd0);
    chk_b("rmid_busy", 0, a_busy, 1'b0);
    chk_b("rmid_ready", 0, a_ready, 1'b1);
    tick();
    chk_b("rmid_bv_held", 0, a_bv, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_b("post_rst_bv", i, a_bv, 1'b0);
      chk_c("post_rst_cnt", i, a_cnt, 3'd0);
    end

    // LSB-first, IDLE_BIT=1 instance: 8'h01.
    w = 8'h01;
    b_step = 1'b1; b_data = w; b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    chk_b("lsb_bv_e0", 0, b_bv, 1'b0);
    chk_b("lsb_idle_e0", 0, b_bit, 1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk_b("lsb_bv", i, b_bv, 1'b1);
      chk_b("lsb_bit", i, b_bit, w[i]);
      tick();
    end
    chk_b("lsb_bv_end", 0, b_bv, 1'b0);
    chk_b("lsb_idle_end", 0, b_bit, 1'b1);
    chk_b("lsb_done_end", 0, b_done, 1'b1);
    chk_b("lsb_busy_end", 0, b_busy, 1'b0);
    chk_b("lsb_ready_end", 0, b_ready, 1'b1);
    chk_c("lsb_cnt_end", 0, b_cnt, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
